rsa_stream_sequencer: RTL and testbench
=======================================

Name: rsa_stream_sequencer

Overview:
- Upstream feeder and result collector for the crypto_rsa core.
- Accepts plaintext words on a valid/ready stream and range-checks each against the modulus.
- Drives the core's reset/load/encrypt pulse sequence, waits for core ready with a timeout, and returns ciphertext (or an error) on an output valid/ready stream.
- One word in flight at a time.

Parameters:
- WIDTH, 32, operand width; must match crypto_rsa WIDTH.
- TO_W, 16, timeout counter width.
- TIMEOUT, 16'hFFFF, max WAIT cycles before abort (1 ≤ TIMEOUT < 2^TO_W).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cfg_key  in  WIDTH  public exponent
- cfg_n  in  WIDTH  modulus
- cfg_we  in  1  latch cfg_key/cfg_n (honoured in IDLE only)
- in_valid  in  1  plaintext word valid
- in_ready  out  1  sequencer accepts plaintext
- in_data  in  WIDTH  plaintext word
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  ciphertext; 0 when out_err=1
- out_err  out  1  1 = plaintext ≥ n, or core timeout
- busy  out  1  state ≠ IDLE
- core_reset  out  1  active-high reset to crypto_rsa
- core_load  out  1  one-cycle load pulse
- core_encrypt  out  1  one-cycle encrypt pulse
- core_key  out  WIDTH  latched key
- core_n  out  WIDTH  latched modulus
- core_plaintext  out  WIDTH  captured plaintext
- core_ready  in  1  crypto_rsa result ready
- core_ciphertext  in  WIDTH  crypto_rsa result

Behaviour:
- Reset (reset_n=0, async):
  - State=IDLE; key_r, n_r, pt_r, out_data_r, to_cnt cleared; cfg_ok=0.
  - out_valid, out_err, core_load, core_encrypt, busy = 0; in_ready=0.
  - core_reset = ~reset_n | to_rst_r, so it is 1 throughout reset.
- cfg_we in IDLE:
  - Latches key_r ← cfg_key and n_r ← cfg_n.
  - cfg_ok ← (cfg_n ≥ 2).
  - cfg_we in any other state is ignored.
- in_ready = (state==IDLE) & cfg_ok & ~cfg_we. It is combinational; cfg_we wins over in_valid in the same cycle.
- FSM states: IDLE, LOAD, GAP, ENC, WAIT, OUT.
  - IDLE, in_valid & in_ready: pt_r ← in_data.
    - If in_data ≥ n_r (unsigned full-width compare): go to OUT with out_err=1, out_data=0. No core pulses.
    - Otherwise go to LOAD.
  - LOAD: core_load=1 for exactly one cycle → GAP.
  - GAP: all core strobes 0 for one cycle → ENC.
  - ENC: core_encrypt=1 for exactly one cycle; to_cnt ← 0 → WAIT.
  - WAIT: to_cnt increments every cycle. core_ready is ignored in the first WAIT cycle (masks a stale ready) and sampled from the second cycle on.
    - core_ready=1: out_data ← core_ciphertext, out_err ← 0 → OUT.
    - Else if to_cnt == TIMEOUT-1: out_data ← 0, out_err ← 1, to_rst_r ← 1 for one cycle (core_reset pulse) → OUT.
    - If both conditions hold in the same cycle, core_ready wins.
  - OUT: out_valid=1; out_data and out_err are held stable until out_ready=1. On out_valid & out_ready → IDLE; the next input may be accepted in the following cycle.
- Latency (no error, core ready K cycles after encrypt): accept edge → core_load at +1, core_encrypt at +3, out_valid at +3+K+1.
- core_key, core_n and core_plaintext are driven from registers continuously; they are stable from LOAD through OUT.
- Reset mid-operation: abort immediately to IDLE. cfg_ok is cleared, so reconfiguration is required before the next input. Any pending result is lost.

Test Plan:
1. Hold reset_n=0 → core_reset=1; out_valid, in_ready, core_load, core_encrypt, busy all 0. Release reset → core_reset=0, in_ready=0 (not configured).
2. cfg key=7, n=143; send plaintext 9; core model asserts ready 20 cycles after encrypt with ciphertext 48 → core_load one cycle after accept, core_encrypt two cycles after that, out_valid with out_data=48, out_err=0.
3. Send plaintext 143, then 200 (n=143) → each gives out_err=1, out_data=0; core_load never pulses.
4. TIMEOUT=16, core_ready stuck 0 → out_err=1, out_data=0 after 16 WAIT cycles; core_reset pulses high for exactly one cycle.
5. Hold out_ready=0 for 5 cycles during OUT → out_valid, out_data=48 and out_err held; in_ready=0; cfg_we ignored (send cfg_n=77, then a second word → still checked against 143).
6. Assert reset_n=0 during WAIT → immediate IDLE with out_valid=0; in_ready=0 until cfg_we; core_ready already high in the first WAIT cycle after restart is ignored.

Source files
------------

// File: rtl/rsa_stream_sequencer.sv
// Stream front end for crypto_rsa: range-checks plaintext against the modulus,
// sequences the core's load/encrypt pulses, and returns ciphertext or an error.
module rsa_stream_sequencer #(
    parameter int          WIDTH   = 32,
    parameter int          TO_W    = 16,
    parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] cfg_key,
    input  logic [WIDTH-1:0] cfg_n,
    input  logic             cfg_we,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             busy,
    output logic             core_reset,
    output logic             core_load,
    output logic             core_encrypt,
    output logic [WIDTH-1:0] core_key,
    output logic [WIDTH-1:0] core_n,
    output logic [WIDTH-1:0] core_plaintext,
    input  logic             core_ready,
    input  logic [WIDTH-1:0] core_ciphertext
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GAP,
        S_ENC,
        S_WAIT,
        S_OUT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] key_q, key_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] pt_q, pt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             cfg_ok_q, cfg_ok_d;
    logic             to_rst_q, to_rst_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            n_q        <= '0;
            pt_q       <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            to_cnt_q   <= '0;
            cfg_ok_q   <= 1'b0;
            to_rst_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            n_q        <= n_d;
            pt_q       <= pt_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
            to_cnt_q   <= to_cnt_d;
            cfg_ok_q   <= cfg_ok_d;
            to_rst_q   <= to_rst_d;
        end
    end

    // Configuration write takes priority over a plaintext offer in IDLE.
    assign in_ready = (state_q == S_IDLE) && cfg_ok_q && !cfg_we;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        n_d        = n_q;
        pt_d       = pt_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        to_cnt_d   = to_cnt_q;
        cfg_ok_d   = cfg_ok_q;
        to_rst_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_we) begin
                    key_d    = cfg_key;
                    n_d      = cfg_n;
                    cfg_ok_d = (cfg_n >= WIDTH'(2));
                end else if (in_valid && cfg_ok_q) begin
                    pt_d = in_data;
                    if (in_data >= n_q) begin
                        out_data_d = '0;
                        out_err_d  = 1'b1;
                        state_d    = S_OUT;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: state_d = S_GAP;
            S_GAP:  state_d = S_ENC;
            S_ENC: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                // First WAIT cycle masks a ready left over from the previous word.
                if ((to_cnt_q != '0) && core_ready) begin
                    out_data_d = core_ciphertext;
                    out_err_d  = 1'b0;
                    state_d    = S_OUT;
                end else if (to_cnt_q == TO_LAST) begin
                    out_data_d = '0;
                    out_err_d  = 1'b1;
                    to_rst_d   = 1'b1;
                    state_d    = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_valid      = (state_q == S_OUT);
    assign out_data       = out_data_q;
    assign out_err        = out_err_q;
    assign busy           = (state_q != S_IDLE);
    assign core_reset     = !reset_n || to_rst_q;
    assign core_load      = (state_q == S_LOAD);
    assign core_encrypt   = (state_q == S_ENC);
    assign core_key       = key_q;
    assign core_n         = n_q;
    assign core_plaintext = pt_q;

endmodule

// File: tb/tb_rsa_stream_sequencer.sv
// Directed bench for rsa_stream_sequencer; a second instance with a short
// timeout exercises the core-timeout abort path.
module tb_rsa_stream_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cfg_key, cfg_n, in_data, core_ciphertext;
    logic        cfg_we, in_valid, out_ready, core_ready;

    logic        in_ready, out_valid, out_err, busy, core_reset, core_load, core_encrypt;
    logic [31:0] out_data, core_key, core_n, core_plaintext;

    logic        t_in_ready, t_out_valid, t_out_err, t_busy, t_core_reset, t_core_load, t_core_encrypt;
    logic [31:0] t_out_data, t_core_key, t_core_n, t_core_plaintext;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rsa_stream_sequencer #(.WIDTH(32), .TO_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_key(cfg_key), .cfg_n(cfg_n), .cfg_we(cfg_we),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
        .busy(busy), .core_reset(core_reset), .core_load(core_load), .core_encrypt(core_encrypt),
        .core_key(core_key), .core_n(core_n), .core_plaintext(core_plaintext),
        .core_ready(core_ready), .core_ciphertext(core_ciphertext)
    );

    rsa_stream_sequencer #(.WIDTH(32), .TO_W(16), .TIMEOUT(16)) dut_to (
        .clk(clk), .reset_n(reset_n),
        .cfg_key(cfg_key), .cfg_n(cfg_n), .cfg_we(cfg_we),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data),
        .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data), .out_err(t_out_err),
        .busy(t_busy), .core_reset(t_core_reset), .core_load(t_core_load), .core_encrypt(t_core_encrypt),
        .core_key(t_core_key), .core_n(t_core_n), .core_plaintext(t_core_plaintext),
        .core_ready(core_ready), .core_ciphertext(core_ciphertext)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic configure(input logic [31:0] k, input logic [31:0] n);
        cfg_key = k;
        cfg_n   = n;
        cfg_we  = 1'b1;
        #1 check_eq("cfg_we_blocks_ready", {31'b0, in_ready}, 32'd0);
        tick();
        cfg_we = 1'b0;
        #1 check_eq("ready_after_cfg", {31'b0, in_ready}, (n >= 2) ? 32'd1 : 32'd0);
    endtask

    task automatic send_word(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1 check_eq("drain_valid_low", {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        reset_n = 1'b0; cfg_key = '0; cfg_n = '0; cfg_we = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        core_ready = 1'b0; core_ciphertext = '0;

        // 1: reset state
        repeat (3) tick();
        check_eq("rst_core_reset", {31'b0, core_reset}, 32'd1);
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check_eq("rst_core_load", {31'b0, core_load}, 32'd0);
        check_eq("rst_core_encrypt", {31'b0, core_encrypt}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        tick();
        check_eq("post_rst_core_reset", {31'b0, core_reset}, 32'd0);
        check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd0);

        // 2: normal encrypt, core ready 20 cycles after encrypt
        configure(32'd7, 32'd143);
        send_word(32'd9);
        check_eq("t2_load", {31'b0, core_load}, 32'd1);
        check_eq("t2_busy", {31'b0, busy}, 32'd1);
        check_eq("t2_pt", core_plaintext, 32'd9);
        check_eq("t2_key", core_key, 32'd7);
        check_eq("t2_n", core_n, 32'd143);
        tick();
        check_eq("t2_gap_load", {31'b0, core_load}, 32'd0);
        check_eq("t2_gap_enc", {31'b0, core_encrypt}, 32'd0);
        tick();
        check_eq("t2_enc", {31'b0, core_encrypt}, 32'd1);
        repeat (20) tick();
        check_eq("t2_wait_valid", {31'b0, out_valid}, 32'd0);
        core_ready = 1'b1;
        core_ciphertext = 32'd48;
        tick();
        core_ready = 1'b0;

        // 5: back-pressure in OUT, cfg_we ignored
        for (int i = 0; i < 5; i++) begin
            check_eq("t5_valid", {31'b0, out_valid}, 32'd1);
            check_eq("t5_data", out_data, 32'd48);
            check_eq("t5_err", {31'b0, out_err}, 32'd0);
            check_eq("t5_in_ready", {31'b0, in_ready}, 32'd0);
            cfg_key = 32'd5;
            cfg_n   = 32'd77;
            cfg_we  = (i == 1);
            tick();
        end
        cfg_we = 1'b0;
        drain();
        check_eq("t5_n_kept", core_n, 32'd143);
        check_eq("t5_key_kept", core_key, 32'd7);
        check_eq("t5_ready_idle", {31'b0, in_ready}, 32'd1);

        // 3: out-of-range plaintext
        send_word(32'd143);
        check_eq("t3a_load", {31'b0, core_load}, 32'd0);
        check_eq("t3a_valid", {31'b0, out_valid}, 32'd1);
        check_eq("t3a_err", {31'b0, out_err}, 32'd1);
        check_eq("t3a_data", out_data, 32'd0);
        drain();
        send_word(32'd200);
        check_eq("t3b_load", {31'b0, core_load}, 32'd0);
        check_eq("t3b_valid", {31'b0, out_valid}, 32'd1);
        check_eq("t3b_err", {31'b0, out_err}, 32'd1);
        check_eq("t3b_data", out_data, 32'd0);
        drain();

        // 100 < 143 but >= 77: proves the ignored cfg write did not land
        send_word(32'd100);
        check_eq("t5b_load", {31'b0, core_load}, 32'd1);
        tick();
        tick();
        check_eq("t5b_enc", {31'b0, core_encrypt}, 32'd1);
        tick();
        core_ready = 1'b1;
        core_ciphertext = 32'h55;
        tick();
        check_eq("t5b_w2_valid", {31'b0, out_valid}, 32'd0);
        tick();
        check_eq("t5b_valid", {31'b0, out_valid}, 32'd1);
        check_eq("t5b_data", out_data, 32'h55);
        check_eq("t5b_err", {31'b0, out_err}, 32'd0);
        core_ready = 1'b0;
        drain();

        // 4: timeout on the TIMEOUT=16 instance
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        configure(32'd7, 32'd143);
        send_word(32'd9);
        check_eq("t4_load", {31'b0, t_core_load}, 32'd1);
        tick();
        tick();
        check_eq("t4_enc", {31'b0, t_core_encrypt}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_eq("t4_wait_valid", {31'b0, t_out_valid}, 32'd0);
            check_eq("t4_wait_core_reset", {31'b0, t_core_reset}, 32'd0);
        end
        tick();
        check_eq("t4_valid", {31'b0, t_out_valid}, 32'd1);
        check_eq("t4_err", {31'b0, t_out_err}, 32'd1);
        check_eq("t4_data", t_out_data, 32'd0);
        check_eq("t4_core_reset_hi", {31'b0, t_core_reset}, 32'd1);
        tick();
        check_eq("t4_core_reset_lo", {31'b0, t_core_reset}, 32'd0);
        check_eq("t4_valid_hold", {31'b0, t_out_valid}, 32'd1);
        check_eq("t4_long_busy", {31'b0, busy}, 32'd1);
        check_eq("t4_long_valid", {31'b0, out_valid}, 32'd0);

        // 6: reset during WAIT, then stale ready after restart
        reset_n = 1'b0;
        #1;
        check_eq("t6_valid", {31'b0, out_valid}, 32'd0);
        check_eq("t6_busy", {31'b0, busy}, 32'd0);
        check_eq("t6_core_reset", {31'b0, core_reset}, 32'd1);
        tick();
        reset_n = 1'b1;
        #1;
        check_eq("t6_rel_core_reset", {31'b0, core_reset}, 32'd0);
        tick();
        check_eq("t6_unconfigured", {31'b0, in_ready}, 32'd0);
        configure(32'd7, 32'd143);
        send_word(32'd9);
        check_eq("t6_load", {31'b0, core_load}, 32'd1);
        tick();
        tick();
        check_eq("t6_enc", {31'b0, core_encrypt}, 32'd1);
        core_ready = 1'b1;
        core_ciphertext = 32'h99;
        tick();
        check_eq("t6_w1_valid", {31'b0, out_valid}, 32'd0);
        core_ciphertext = 32'h77;
        tick();
        check_eq("t6_stale_masked", {31'b0, out_valid}, 32'd0);
        tick();
        check_eq("t6_valid_out", {31'b0, out_valid}, 32'd1);
        check_eq("t6_data", out_data, 32'h77);
        core_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
